// File: rtl/frac_clk_gen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
package frac_clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  localparam int SETTLE_CNT_W = 16;

  // Channel-select width; a single channel still needs a one-bit select port.
  function automatic int chan_sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/frac_clk_gen_chan.sv
// One phase-accumulator channel: config registers, accumulator, carry pulse and MSB level.
module frac_clk_gen_chan
  import frac_clk_gen_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ACC_WIDTH-1:0] wr_incr,
  input  logic [ACC_WIDTH-1:0] wr_phase,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 pulse_ok,
  input  logic                 level_clr,
  output logic                 clk_en,
  output logic                 clk_level
);

  logic [ACC_WIDTH-1:0] incr_q;
  logic [ACC_WIDTH-1:0] phase_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;

  assign {carry, sum} = {1'b0, acc_q} + {1'b0, incr_q};

  always_comb begin
    acc_next = acc_q;
    if (load) begin
      acc_next = phase_q;
    end else if (advance) begin
      acc_next = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      incr_q  <= '0;
      phase_q <= '0;
    end else if (wr_en) begin
      incr_q  <= wr_incr;
      phase_q <= wr_phase;
    end
  end

  // Level tracks the accumulator MSB it will hold next cycle, so it stays aligned with acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      clk_en    <= 1'b0;
      clk_level <= 1'b0;
    end else begin
      acc_q     <= acc_next;
      clk_en    <= advance && pulse_ok && carry;
      clk_level <= !level_clr && acc_next[ACC_WIDTH-1];
    end
  end

endmodule

// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock-enable generator with align/settle/lock sequencing.
module frac_clk_gen
  import frac_clk_gen_pkg::*;
#(
  parameter  int CHANNELS    = 3,
  parameter  int ACC_WIDTH   = 32,
  parameter  int LOCK_CYCLES = 16,
  localparam int CHAN_W      = chan_sel_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [ACC_WIDTH-1:0] cfg_incr,
  input  logic [ACC_WIDTH-1:0] cfg_phase,
  output logic [CHANNELS-1:0]  clk_en,
  output logic [CHANNELS-1:0]  clk_level,
  output logic                 locked
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(LOCK_CYCLES - 1);

  logic [1:0]              rst_sync;
  logic                    rst_n;
  state_t                  state;
  state_t                  next_state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    wr_fire;
  logic                    load_all;
  logic                    advance;
  logic                    pulse_ok;
  logic                    level_clr;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n   = rst_sync[1];
  assign wr_fire = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping run wins over a realign request from a simultaneous write.
  always_comb begin
    next_state = state;
    if (!run) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   next_state = ST_ALIGN;
        ST_ALIGN:  next_state = ST_SETTLE;
        ST_SETTLE: begin
          if (wr_fire) begin
            next_state = ST_ALIGN;
          end else if (settle_cnt == SETTLE_LAST) begin
            next_state = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (wr_fire) begin
            next_state = ST_ALIGN;
          end
        end
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state != ST_ALIGN);
    load_all  = (state == ST_ALIGN);
    advance   = (state == ST_SETTLE) || (state == ST_LOCKED);
    pulse_ok  = (next_state == ST_SETTLE) || (next_state == ST_LOCKED);
    level_clr = (next_state == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      settle_cnt <= ((state == ST_SETTLE) && (next_state == ST_SETTLE)) ? settle_cnt + 1'b1 : '0;
      locked     <= (next_state == ST_LOCKED);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    frac_clk_gen_chan #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_fire && (cfg_chan == CHAN_W'(i))),
      .wr_incr  (cfg_incr),
      .wr_phase (cfg_phase),
      .load     (load_all),
      .advance  (advance),
      .pulse_ok (pulse_ok),
      .level_clr(level_clr),
      .clk_en   (clk_en[i]),
      .clk_level(clk_level[i])
    );
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Self-checking bench: directed table, corner-case sequences and randomized traffic vs. a reference model.
module tb_frac_clk_gen;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int LC = 4;
  localparam int MOD = 1 << W;

  localparam int M_IDLE   = 0;
  localparam int M_ALIGN  = 1;
  localparam int M_SETTLE = 2;
  localparam int M_LOCKED = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan = '0;
  logic [W-1:0]  cfg_incr = '0;
  logic [W-1:0]  cfg_phase = '0;
  logic [CH-1:0] clk_en;
  logic [CH-1:0] clk_level;
  logic          locked;

  int checks = 0;
  int errors = 0;

  int            m_state;
  int            m_settle;
  int unsigned   m_acc[CH];
  int unsigned   m_incr[CH];
  int unsigned   m_phase[CH];
  logic [CH-1:0] m_pulse;

  typedef struct packed {
    logic          r;
    logic          v;
    logic [1:0]    c;
    logic [W-1:0]  inc;
    logic [W-1:0]  ph;
    logic [CH-1:0] en;
    logic [CH-1:0] lvl;
    logic          lock;
    logic          rdy;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  frac_clk_gen #(
    .CHANNELS(CH),
    .ACC_WIDTH(W),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_incr (cfg_incr),
    .cfg_phase(cfg_phase),
    .clk_en   (clk_en),
    .clk_level(clk_level),
    .locked   (locked)
  );

  task automatic modelReset();
    m_state  = M_IDLE;
    m_settle = 0;
    m_pulse  = '0;
    for (int i = 0; i < CH; i++) begin
      m_acc[i]   = 0;
      m_incr[i]  = 0;
      m_phase[i] = 0;
    end
  endtask

  function automatic logic [CH-1:0] modelLevel();
    logic [CH-1:0] l;
    for (int i = 0; i < CH; i++) begin
      l[i] = (m_state != M_IDLE) && (m_acc[i] >= MOD / 2);
    end
    return l;
  endfunction

  // One clock of the behavioural model, using the register values from before the edge.
  task automatic modelStep(input logic r, input logic v, input int c, input int unsigned inc, input int unsigned ph);
    int          nxt;
    bit          wr;
    int unsigned sum;
    wr  = v && (m_state != M_ALIGN);
    nxt = m_state;
    if (!r) begin
      nxt = M_IDLE;
    end else if (m_state == M_IDLE) begin
      nxt = M_ALIGN;
    end else if (m_state == M_ALIGN) begin
      nxt = M_SETTLE;
    end else if (wr) begin
      nxt = M_ALIGN;
    end else if (m_state == M_SETTLE && m_settle + 1 == LC) begin
      nxt = M_LOCKED;
    end
    for (int i = 0; i < CH; i++) begin
      m_pulse[i] = 1'b0;
      if (m_state == M_ALIGN) begin
        m_acc[i] = m_phase[i];
      end else if (m_state == M_SETTLE || m_state == M_LOCKED) begin
        sum        = m_acc[i] + m_incr[i];
        m_acc[i]   = sum % MOD;
        m_pulse[i] = (sum >= MOD) && (nxt == M_SETTLE || nxt == M_LOCKED);
      end
    end
    m_settle = (m_state == M_SETTLE && nxt == M_SETTLE) ? m_settle + 1 : 0;
    if (wr && c < CH) begin
      m_incr[c]  = inc % MOD;
      m_phase[c] = ph % MOD;
    end
    m_state = nxt;
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [CH-1:0] e_en, input logic [CH-1:0] e_lvl,
                             input logic e_lock, input logic e_rdy);
    checkVal({name, ".clk_en"}, 32'(clk_en), 32'(e_en));
    checkVal({name, ".clk_level"}, 32'(clk_level), 32'(e_lvl));
    checkVal({name, ".locked"}, 32'(locked), 32'(e_lock));
    checkVal({name, ".cfg_ready"}, 32'(cfg_ready), 32'(e_rdy));
  endtask

  task automatic applyStimulus(input logic r, input logic v, input int c, input int unsigned inc,
                               input int unsigned ph, input bit chk);
    run       = r;
    cfg_valid = v;
    cfg_chan  = c[1:0];
    cfg_incr  = inc[W-1:0];
    cfg_phase = ph[W-1:0];
    if (chk) begin
      checkOutput("model", m_pulse, modelLevel(), m_state == M_LOCKED, m_state != M_ALIGN);
    end
    @(posedge clk);
    modelStep(r, v, c, inc, ph);
    #1;
  endtask

  task automatic hold(input logic r, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(r, 1'b0, 0, 0, 0, 1'b1);
    end
  endtask

  initial begin
    logic [15:0] pat0;
    logic [15:0] pat1;
    int          cnt;
    int          bad;
    int          n;

    tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'h40, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b001, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b001, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b001, 3'b000, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b001, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b000, 3'b001, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 3'b001, 3'b000, 1'b1, 1'b1};

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 3'b000, 3'b000, 1'b0, 1'b1);
    reset_n = 1'b1;
    hold(1'b0, 3);

    // Single channel at a quarter rate: align, settle, lock and pulse cadence.
    for (int k = 0; k < 11; k++) begin
      checkOutput($sformatf("vec%0d", k), tbl[k].en, tbl[k].lvl, tbl[k].lock, tbl[k].rdy);
      applyStimulus(tbl[k].r, tbl[k].v, int'(tbl[k].c), int'(tbl[k].inc), int'(tbl[k].ph), 1'b0);
    end

    // 3/8 rate: three pulses in any eight locked cycles, repeating.
    applyStimulus(1'b1, 1'b1, 0, 'h60, 'h00, 1'b1);
    hold(1'b1, 6);
    for (int k = 0; k < 16; k++) begin
      pat0[k] = clk_en[0];
      hold(1'b1, 1);
    end
    cnt = 0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      cnt += int'(pat0[k]);
      if (pat0[k] !== pat0[k+8]) bad++;
    end
    checkVal("rate_3of8_count", 32'(cnt), 32'd3);
    checkVal("rate_3of8_repeat", 32'(bad), 32'd0);

    // Two channels half a turn apart: opposite levels, pulses four cycles apart.
    applyStimulus(1'b1, 1'b1, 0, 'h20, 'h00, 1'b1);
    hold(1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1, 'h20, 'h80, 1'b1);
    hold(1'b1, 6);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      pat0[k] = clk_en[0];
      pat1[k] = clk_en[1];
      if (clk_level[0] === clk_level[1]) bad++;
      hold(1'b1, 1);
    end
    checkVal("antiphase_level", 32'(bad), 32'd0);
    bad = 0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (pat0[k] !== pat1[k+4]) bad++;
    end
    for (int k = 0; k < 16; k++) cnt += int'(pat0[k]);
    checkVal("antiphase_pulse_offset", 32'(bad), 32'd0);
    checkVal("antiphase_pulse_count", 32'(cnt), 32'd2);

    // Reconfigure while locked: realign and relock after the settle window.
    applyStimulus(1'b1, 1'b1, 2, 'h80, 'h40, 1'b1);
    checkVal("relock_ready_low", 32'(cfg_ready), 32'd0);
    checkVal("relock_locked_low", 32'(locked), 32'd0);
    n = 0;
    while (locked !== 1'b1 && n < 20) begin
      hold(1'b1, 1);
      n++;
    end
    checkVal("relock_cycles", 32'(n), 32'd5);

    // Stop during settle, then an out-of-range channel write that must change nothing.
    applyStimulus(1'b1, 1'b1, 0, 'h33, 'h10, 1'b1);
    hold(1'b1, 2);
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
    checkOutput("stop_in_settle", 3'b000, 3'b000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3, 'hFF, 'hFF, 1'b1);
    hold(1'b0, 1);
    hold(1'b1, 12);

    // Asynchronous reset while locked discards all configuration.
    #2;
    reset_n = 1'b0;
    run     = 1'b0;
    #1;
    checkOutput("async_reset", 3'b000, 3'b000, 1'b0, 1'b1);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(1'b0, 3);
    hold(1'b1, 10);
    checkOutput("post_reset_cfg_cleared", 3'b000, 3'b000, 1'b1, 1'b1);

    for (int k = 0; k < 600; k++) begin
      int unsigned inc;
      int          sel;
      sel = int'($urandom_range(0, 3));
      inc = (sel == 0) ? 0 : (sel == 1) ? 'h80 : ($urandom & 'hFF);
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, CH - 1)), inc, $urandom & 'hFF, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
